dmem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port data memory between the four-stage processor's load/store path (port 0) and the NIC/DMA side (port 1). Each cycle it selects at most one request and drives it onto the memory port. It returns read data one cycle later, tagged back to the port that issued the read. Arbitration is round-robin, with an optional bounded lock for multi-beat transfers.

---
 rtl/dmem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_dmem_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU
// load/store path (port 0) and the NIC/DMA side (port 1), with a bounded lock.
module dmem_port_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_wr,
  input  logic              p0_lock,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_wr,
  input  logic              p1_lock,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  // Handshake: a port holds req/wr/addr/wdata stable until it sees gnt in the
  // same cycle; read data comes back on that port's rvalid one cycle later.
  localparam logic [8:0] LOCK_LIMIT = 9'(LOCK_MAX);

  logic       last_gnt_q, last_gnt_d;
  logic       lock_owner_valid_q, lock_owner_valid_d;
  logic       lock_owner_q, lock_owner_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_port_q, rd_port_d;

  logic       gnt_any, gnt_port, gnt_wr, gnt_lock;
  logic       other_req, owner_req, lock_hold;
  logic [7:0] cnt_base;
  logic [8:0] cnt_next;

  always_comb begin
    lock_hold = lock_owner_valid_q && ({1'b0, lock_cnt_q} < LOCK_LIMIT);
    gnt_any   = !reset && (p0_req || p1_req);
    if (p0_req && p1_req) gnt_port = lock_hold ? lock_owner_q : ~last_gnt_q;
    else                  gnt_port = p1_req;
    gnt_wr    = gnt_port ? p1_wr   : p0_wr;
    gnt_lock  = gnt_port ? p1_lock : p0_lock;
    other_req = gnt_port ? p0_req  : p1_req;
    owner_req = lock_owner_q ? p1_req : p0_req;
  end

  assign p0_gnt    = gnt_any && !gnt_port;
  assign p1_gnt    = gnt_any &&  gnt_port;
  assign mem_en    = gnt_any;
  assign mem_wr_en = gnt_any && gnt_wr;
  assign mem_addr  = gnt_any ? (gnt_port ? p1_addr  : p0_addr)  : '0;
  assign mem_wdata = gnt_any ? (gnt_port ? p1_wdata : p0_wdata) : '0;

  assign p0_rvalid = rd_pend_q && !rd_port_q;
  assign p1_rvalid = rd_pend_q &&  rd_port_q;
  assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
  assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

  always_comb begin
    last_gnt_d         = last_gnt_q;
    lock_owner_valid_d = lock_owner_valid_q;
    lock_owner_d       = lock_owner_q;
    lock_cnt_d         = lock_cnt_q;
    cnt_base           = '0;
    cnt_next           = '0;

    if (gnt_any) last_gnt_d = gnt_port;

    if (lock_owner_valid_q && !owner_req) begin
      lock_owner_valid_d = 1'b0;
      lock_cnt_d         = '0;
    end

    if (gnt_any) begin
      if (gnt_lock) begin
        // The grant that establishes a lock already counts against the budget.
        cnt_base = (lock_owner_valid_q && (lock_owner_q == gnt_port)) ? lock_cnt_q : 8'd0;
        cnt_next = {1'b0, cnt_base} + 9'd1;
        lock_owner_d       = gnt_port;
        lock_owner_valid_d = 1'b1;
        lock_cnt_d         = cnt_base;
        if (other_req) begin
          if (cnt_next >= LOCK_LIMIT) begin
            lock_owner_valid_d = 1'b0;
            lock_cnt_d         = '0;
          end else begin
            lock_cnt_d = cnt_next[7:0];
          end
        end
      end else if (lock_owner_valid_q && (lock_owner_q == gnt_port)) begin
        lock_owner_valid_d = 1'b0;
        lock_cnt_d         = '0;
      end
    end

    rd_pend_d = gnt_any && !gnt_wr;
    rd_port_d = gnt_any ? gnt_port : rd_port_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt_q         <= 1'b1;
      lock_owner_valid_q <= 1'b0;
      lock_owner_q       <= 1'b0;
      lock_cnt_q         <= '0;
      rd_pend_q          <= 1'b0;
      rd_port_q          <= 1'b0;
    end else begin
      last_gnt_q         <= last_gnt_d;
      lock_owner_valid_q <= lock_owner_valid_d;
      lock_owner_q       <= lock_owner_d;
      lock_cnt_q         <= lock_cnt_d;
      rd_pend_q          <= rd_pend_d;
      rd_port_q          <= rd_port_d;
    end
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small registered-read memory.
module tb_dmem_port_arbiter;
  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 32;
  localparam int LOCK_MAX = 8;

  logic clk = 1'b0;
  logic reset;
  logic p0_req, p0_wr, p0_lock, p1_req, p1_wr, p1_lock;
  logic [ADDR_W-1:0] p0_addr, p1_addr, mem_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata, mem_wdata, p0_rdata, p1_rdata;
  logic p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_en, mem_wr_en;
  logic [DATA_W-1:0] mem_rdata = '0;

  logic [DATA_W-1:0] mem [0:255];
  logic [255:0]      wr_seen = '0;

  int errors = 0;
  int checks = 0;

  dmem_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Unwritten locations read as a fixed pattern; 0x10 holds 0xDEAD.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr_en) begin
        mem[mem_addr[7:0]]     <= mem_wdata;
        wr_seen[mem_addr[7:0]] <= 1'b1;
      end else if (wr_seen[mem_addr[7:0]]) begin
        mem_rdata <= mem[mem_addr[7:0]];
      end else if (mem_addr[7:0] == 8'h10) begin
        mem_rdata <= 64'hDEAD;
      end else begin
        mem_rdata <= 64'hC0DE_0000 | {56'd0, mem_addr[7:0]};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached without summary, required completion");
    $fatal(1);
  end

  // driver tasks
  task automatic drive_p0(input logic req, input logic wr, input logic lock,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    p0_req = req; p0_wr = wr; p0_lock = lock; p0_addr = addr; p0_wdata = wdata;
  endtask

  task automatic drive_p1(input logic req, input logic wr, input logic lock,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    p1_req = req; p1_wr = wr; p1_lock = lock; p1_addr = addr; p1_wdata = wdata;
  endtask

  task automatic idle_ports();
    drive_p0(1'b0, 1'b0, 1'b0, '0, '0);
    drive_p1(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle_ports();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_p0(1'b1, 1'b1, 1'b0, 32'h8, 64'h55);
    drive_p1(1'b1, 1'b0, 1'b0, 32'h9, 64'h66);
    @(negedge clk); #1;
    checks++;
    if ({p0_gnt, p1_gnt, mem_en, mem_wr_en, p0_rvalid, p1_rvalid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {p0_gnt, p1_gnt, mem_en, mem_wr_en, p0_rvalid, p1_rvalid});
    end
    checks++;
    if ({mem_addr, mem_wdata, p0_rdata, p1_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: addr=%0h wdata=%0h rd0=%0h rd1=%0h required all 0",
               mem_addr, mem_wdata, p0_rdata, p1_rdata);
    end
    idle_ports();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({p0_gnt, p1_gnt, mem_en, p0_rvalid, p1_rvalid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_idle: got %b required 00000", {p0_gnt, p1_gnt, mem_en, p0_rvalid, p1_rvalid});
    end
  endtask

  task automatic test_single_read();
    @(negedge clk);
    drive_p0(1'b1, 1'b0, 1'b0, 32'h10, '0);
    #1;
    checks++;
    if ({p0_gnt, p1_gnt, mem_en, mem_wr_en} !== 4'b1010 || mem_addr !== 32'h10) begin
      errors++;
      $display("FAIL single_grant: gnt=%b en/wr=%b addr=%0h required 10 10 10",
               {p0_gnt, p1_gnt}, {mem_en, mem_wr_en}, mem_addr);
    end
    @(negedge clk);
    idle_ports();
    #1;
    checks++;
    if ({p0_rvalid, p1_rvalid} !== 2'b10 || p0_rdata !== 64'hDEAD || p1_rdata !== '0) begin
      errors++;
      $display("FAIL single_rvalid: rvalid=%b rd0=%0h rd1=%0h required 10 dead 0",
               {p0_rvalid, p1_rvalid}, p0_rdata, p1_rdata);
    end
    checks++;
    if (mem_en !== 1'b0) begin
      errors++;
      $display("FAIL single_idle_en: got %b required 0", mem_en);
    end
    @(negedge clk); #1;
    checks++;
    if ({p0_rvalid, p1_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL single_rvalid_drop: got %b required 00", {p0_rvalid, p1_rvalid});
    end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_gnt, prev_gnt;
    apply_reset();
    prev_gnt = 2'b00;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c < 6) begin
        drive_p0(1'b1, 1'b0, 1'b0, 32'h20, '0);
        drive_p1(1'b1, 1'b0, 1'b0, 32'h21, '0);
      end else begin
        idle_ports();
      end
      #1;
      exp_gnt = (c == 6) ? 2'b00 : ((c % 2 == 0) ? 2'b10 : 2'b01);
      checks++;
      if ({p0_gnt, p1_gnt} !== exp_gnt) begin
        errors++;
        $display("FAIL alt_gnt c%0d: got %b required %b", c, {p0_gnt, p1_gnt}, exp_gnt);
      end
      if (c > 0) begin
        checks++;
        if ({p0_rvalid, p1_rvalid} !== prev_gnt ||
            p0_rdata !== (prev_gnt[1] ? 64'hC0DE_0020 : 64'h0) ||
            p1_rdata !== (prev_gnt[0] ? 64'hC0DE_0021 : 64'h0)) begin
          errors++;
          $display("FAIL alt_rvalid c%0d: rvalid=%b rd0=%0h rd1=%0h required rvalid %b",
                   c, {p0_rvalid, p1_rvalid}, p0_rdata, p1_rdata, prev_gnt);
        end
      end
      prev_gnt = exp_gnt;
    end
  endtask

  task automatic test_lock_limit();
    logic [1:0] exp_gnt;
    apply_reset();
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      drive_p0(1'b1, 1'b1, 1'b0, 32'h50, 64'h5050);
      drive_p1(1'b1, 1'b1, 1'b1, 32'h40, 64'h1111);
      #1;
      exp_gnt = (c == 0 || c == 9) ? 2'b10 : 2'b01;
      checks++;
      if ({p0_gnt, p1_gnt} !== exp_gnt || mem_wr_en !== 1'b1 ||
          mem_addr !== (exp_gnt[1] ? 32'h50 : 32'h40) ||
          mem_wdata !== (exp_gnt[1] ? 64'h5050 : 64'h1111)) begin
        errors++;
        $display("FAIL lock_gnt c%0d: gnt=%b wr=%b addr=%0h required gnt %b",
                 c, {p0_gnt, p1_gnt}, mem_wr_en, mem_addr, exp_gnt);
      end
      checks++;
      if ({p0_rvalid, p1_rvalid} !== 2'b00) begin
        errors++;
        $display("FAIL lock_no_rvalid c%0d: got %b required 00", c, {p0_rvalid, p1_rvalid});
      end
    end
    @(negedge clk);
    idle_ports();
  endtask

  task automatic test_write_then_read();
    @(negedge clk);
    drive_p0(1'b1, 1'b1, 1'b0, 32'h4, 64'h1234);
    #1;
    checks++;
    if ({p0_gnt, p1_gnt, mem_wr_en} !== 3'b101 || mem_wdata !== 64'h1234 || mem_addr !== 32'h4) begin
      errors++;
      $display("FAIL raw_write: gnt=%b wr=%b wdata=%0h addr=%0h required 10 1 1234 4",
               {p0_gnt, p1_gnt}, mem_wr_en, mem_wdata, mem_addr);
    end
    @(negedge clk);
    idle_ports();
    drive_p1(1'b1, 1'b0, 1'b0, 32'h4, '0);
    #1;
    checks++;
    if ({p0_gnt, p1_gnt, mem_wr_en, p0_rvalid, p1_rvalid} !== 5'b01000) begin
      errors++;
      $display("FAIL raw_read_gnt: got %b required 01000",
               {p0_gnt, p1_gnt, mem_wr_en, p0_rvalid, p1_rvalid});
    end
    @(negedge clk);
    idle_ports();
    #1;
    checks++;
    if ({p0_rvalid, p1_rvalid} !== 2'b01 || p1_rdata !== 64'h1234) begin
      errors++;
      $display("FAIL raw_rdata: rvalid=%b rd1=%0h required 01 1234", {p0_rvalid, p1_rvalid}, p1_rdata);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    @(negedge clk);
    drive_p1(1'b1, 1'b0, 1'b1, 32'h21, '0);
    #1;
    checks++;
    if ({p0_gnt, p1_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL rmid_lock_gnt: got %b required 01", {p0_gnt, p1_gnt});
    end
    @(negedge clk);
    drive_p0(1'b1, 1'b0, 1'b0, 32'h10, '0);
    #1;
    checks++;
    if ({p0_gnt, p1_gnt, p1_rvalid} !== 3'b011 || p1_rdata !== 64'hC0DE_0021) begin
      errors++;
      $display("FAIL rmid_pre: gnt=%b rv1=%b rd1=%0h required 01 1 c0de0021",
               {p0_gnt, p1_gnt}, p1_rvalid, p1_rdata);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({p0_gnt, p1_gnt, mem_en, mem_wr_en} !== 4'b0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL rmid_async: gnt=%b en=%b addr=%0h required 00 0 0",
               {p0_gnt, p1_gnt}, mem_en, mem_addr);
    end
    @(negedge clk); #1;
    checks++;
    if ({p0_rvalid, p1_rvalid} !== 2'b00 || p1_rdata !== '0) begin
      errors++;
      $display("FAIL rmid_discard: rvalid=%b rd1=%0h required 00 0", {p0_rvalid, p1_rvalid}, p1_rdata);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({p0_gnt, p1_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL rmid_first_contention: got %b required 10", {p0_gnt, p1_gnt});
    end
    @(negedge clk);
    idle_ports();
    #1;
    checks++;
    if ({p0_rvalid, p1_rvalid} !== 2'b10 || p0_rdata !== 64'hDEAD) begin
      errors++;
      $display("FAIL rmid_after: rvalid=%b rd0=%0h required 10 dead", {p0_rvalid, p1_rvalid}, p0_rdata);
    end
  endtask

  task automatic test_lock_drop();
    logic [1:0] exp_gnt;
    apply_reset();
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      drive_p0(1'b1, 1'b1, 1'b0, 32'h60, 64'h6060);
      drive_p1((c != 3), 1'b1, 1'b1, 32'h61, 64'h6161);
      #1;
      exp_gnt = (c == 0 || c == 3 || c == 12) ? 2'b10 : 2'b01;
      checks++;
      if ({p0_gnt, p1_gnt} !== exp_gnt) begin
        errors++;
        $display("FAIL lockdrop_gnt c%0d: got %b required %b", c, {p0_gnt, p1_gnt}, exp_gnt);
      end
    end
    @(negedge clk);
    idle_ports();
  endtask

  initial begin
    idle_ports();
    test_reset();
    test_single_read();
    test_alternate();
    test_lock_limit();
    test_write_then_read();
    test_reset_mid();
    test_lock_drop();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
